// File: rtl/uart_receive_if.sv
// uart_receive_if
// Bus-side signal bundle between the UART receiver and its consumer.
//   receive_read_en    consumer -> receiver : one-cycle acknowledge of the held byte
//   receive_read_line  receiver -> consumer : last completed byte
//   rda                receiver -> consumer : receive data available
//   framing_err        receiver -> consumer : held byte's stop bit was sampled low
//   overrun            receiver -> consumer : a byte completed while rda was still set
// Modport master is the receiver side, modport slave is the consumer side.
interface uart_receive_if;
    logic       receive_read_en;
    logic [7:0] receive_read_line;
    logic       rda;
    logic       framing_err;
    logic       overrun;

    modport master (
        input  receive_read_en,
        output receive_read_line,
        output rda,
        output framing_err,
        output overrun
    );

    modport slave (
        output receive_read_en,
        input  receive_read_line,
        input  rda,
        input  framing_err,
        input  overrun
    );
endinterface

// File: rtl/uart_receive.sv
// uart_receive
// 8N1 serial receiver driven by a 16x oversample strobe. The asynchronous
// rxd line is synchronised, a falling edge starts a frame, the start bit is
// re-checked at mid-bit, eight data bits are sampled LSB first at mid-bit and
// the stop bit is sampled 16 strobes later. Each completed byte is held on the
// bus together with data-available, framing-error and overrun flags.
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   receive_baud  one-clk strobe at 16x the bit rate
//   rxd           serial input, idle high, asynchronous to clk
//   bus           uart_receive_if.master (read_en in; byte and flags out)
module uart_receive (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          receive_baud,
    input  logic          rxd,
    uart_receive_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_s;

    logic       rxd_s1;
    logic       rxd_sync;
    logic       rxd_prev;
    logic       fall_s;

    logic [3:0] os_cnt;
    logic [3:0] os_cnt_s;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_s;
    logic [7:0] rx_shft;
    logic [7:0] rx_shft_s;
    logic       complete_s;

    logic [7:0] read_line_r;
    logic [7:0] read_line_s;
    logic       rda_r;
    logic       rda_s;
    logic       framing_err_r;
    logic       framing_err_s;
    logic       overrun_r;
    logic       overrun_s;

    // Start edge: line was high one cycle ago and is low now.
    assign fall_s = rxd_prev & ~rxd_sync;

    // Two-flop synchroniser plus edge-history flop, all idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1   <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= rxd;
            rxd_sync <= rxd_s1;
            rxd_prev <= rxd_sync;
        end
    end

    // FSM state, oversample/bit counters and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            os_cnt  <= 4'd0;
            bit_cnt <= 3'd0;
            rx_shft <= 8'h00;
        end else begin
            state_r <= state_s;
            os_cnt  <= os_cnt_s;
            bit_cnt <= bit_cnt_s;
            rx_shft <= rx_shft_s;
        end
    end

    // Next-state logic: frame tracking on oversample strobes.
    always_comb begin
        state_s    = state_r;
        os_cnt_s   = os_cnt;
        bit_cnt_s  = bit_cnt;
        rx_shft_s  = rx_shft;
        complete_s = 1'b0;
        case (state_r)
            IDLE: begin
                // Strobes are ignored here; an edge wins even if a strobe
                // coincides, so the count restarts cleanly at zero.
                if (fall_s) begin
                    os_cnt_s = 4'd0;
                    state_s  = START;
                end else begin
                    state_s  = IDLE;
                end
            end
            START: begin
                if (receive_baud) begin
                    if (os_cnt == 4'd7) begin
                        // Mid start bit: still low means a real start.
                        if (!rxd_sync) begin
                            os_cnt_s  = 4'd0;
                            bit_cnt_s = 3'd0;
                            state_s   = DATA;
                        end else begin
                            state_s   = IDLE;
                        end
                    end else begin
                        os_cnt_s = os_cnt + 4'd1;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (receive_baud) begin
                    os_cnt_s = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        rx_shft_s = {rxd_sync, rx_shft[7:1]};
                        bit_cnt_s = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_s = STOP;
                        end else begin
                            state_s = DATA;
                        end
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (receive_baud) begin
                    os_cnt_s = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        complete_s = 1'b1;
                        state_s    = IDLE;
                    end else begin
                        state_s    = STOP;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next values of the held byte and flags; completion beats a same-cycle read.
    always_comb begin
        read_line_s   = read_line_r;
        rda_s         = rda_r;
        framing_err_s = framing_err_r;
        overrun_s     = overrun_r;
        if (complete_s) begin
            read_line_s   = rx_shft;
            rda_s         = 1'b1;
            framing_err_s = ~rxd_sync;
            if (rda_r && !bus.receive_read_en) begin
                overrun_s = 1'b1;
            end else begin
                overrun_s = overrun_r;
            end
        end else if (bus.receive_read_en) begin
            rda_s     = 1'b0;
            overrun_s = 1'b0;
        end else begin
            rda_s     = rda_r;
            overrun_s = overrun_r;
        end
    end

    // Registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_line_r   <= 8'h00;
            rda_r         <= 1'b0;
            framing_err_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            read_line_r   <= read_line_s;
            rda_r         <= rda_s;
            framing_err_r <= framing_err_s;
            overrun_r     <= overrun_s;
        end
    end

    assign bus.receive_read_line = read_line_r;
    assign bus.rda               = rda_r;
    assign bus.framing_err       = framing_err_r;
    assign bus.overrun           = overrun_r;

endmodule

// File: doc/uart_receive.md
# uart_receive

Serial receiver for the UART path. It consumes the `txd` line produced by the transmitter, possibly looped back or routed off-chip, and presents it on `rxd`. It recovers 8N1 frames using a 16x oversample enable from the shared baud generator and presents each byte with a ready flag, framing-error flag and overrun flag to the bus interface.

## Interface
- Parameters: none. Fixed 8 data bits, no parity, 1 stop bit, 16x oversampling.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `receive_baud`  in  1  one-`clk` strobe at 16x the bit rate, from the baud generator.
- `rxd`  in  1  serial input, idle high, asynchronous to `clk`.
- `receive_read_en`  in  1  one-cycle consumer acknowledge of the held byte.
- `receive_read_line`  out  8  last completed byte.
- `rda`  out  1  receive data available.
- `framing_err`  out  1  the held byte's stop bit sampled low.
- `overrun`  out  1  a byte completed while `rda` was still set.

## Operation
- **Synchronizer:** two flops, `rxd_s1`→`rxd_sync`, plus an edge-history flop `rxd_prev`. All three reset to 1.
- **Counters:** `os_cnt` is 4 bits and counts `receive_baud` strobes; it wraps 15→0. `bit_cnt` is 3 bits. Both reset to 0.
- **Shift register:** `rx_shft` is 8 bits and shifts right. The new sample enters at bit 7, so data arrives LSB first.
- **FSM:** states IDLE, START, DATA, STOP; reset state IDLE.
  - **IDLE:** on `rxd_prev`=1 and `rxd_sync`=0 (falling edge), clear `os_cnt` and go to START. `receive_baud` is not needed for this transition.
  - **START:** increment `os_cnt` on each strobe. On the strobe where `os_cnt`==7 (mid start bit):
    - if `rxd_sync`=0, clear `os_cnt` and `bit_cnt`, then go to DATA;
    - otherwise return to IDLE (glitch rejected; no flags change).
  - **DATA:** increment `os_cnt` on each strobe. On the strobe where `os_cnt`==15, sample `rxd_sync` into `rx_shft` and increment `bit_cnt`. `os_cnt` wraps to 0 on that strobe. After the sample with `bit_cnt`==7, go to STOP with `bit_cnt` wrapping to 0.
  - **STOP:** on the strobe where `os_cnt`==15, perform the completion event below, then go to IDLE.
- **Completion event** (a single cycle):
  - `receive_read_line` <= `rx_shft`.
  - `rda` <= 1.
  - `framing_err` <= ~`rxd_sync`.
  - `overrun` <= 1 if `rda`==1 and `receive_read_en`==0 in that cycle; otherwise `overrun` keeps its current value.
- **Read:**
  - `receive_read_en` with no completion in that cycle: `rda` <= 0 and `overrun` <= 0.
  - `receive_read_en` in the same cycle as a completion: the completion wins, `rda` stays 1 and `overrun` is not set.
  - `receive_read_line` and `framing_err` are held until the next completion.
- **Break / stuck-low line:** after a framing error the FSM sits in IDLE. A new start requires a fresh falling edge, so a held-low line produces exactly one frame.
- `receive_baud` pulses during IDLE are ignored, and `os_cnt` holds.

## Timing
- Reset values:
  - `receive_read_line`=8'h00, `rda`=0, `framing_err`=0, `overrun`=0.
  - State IDLE, `rx_shft`=8'h00.
  - `rxd_s1`, `rxd_sync`, `rxd_prev` all 1.
- **Synchronizer latency:** 2 `clk` from `rxd` to `rxd_sync`.
- **Sample points:**
  - Start-bit check: 8th strobe after the edge is detected.
  - Data bits: every following 16th strobe, at mid-bit.
  - Stop bit: 16 strobes after data bit 7.
- **Frame latency:** the completion occurs 8+16·9 = 152 strobes after edge detection. `rda` is visible the `clk` after the strobe at which completion occurs.
- **Outputs:** all are registered, and none is combinational from inputs.
- **Reset mid-frame:** an asynchronous return to IDLE with all outputs cleared. The partially received frame is discarded.
- **Back-to-back frames:** a start edge arriving immediately after the stop sample must be detected, with no dead cycle beyond the synchronizer.
- **Same-cycle edge and strobe in IDLE:** the edge is taken. That strobe does not count, and `os_cnt` stays 0.

## Test plan
- **Normal frame:** `receive_baud` pulses every 4 `clk`; drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1).
  - Required: `receive_read_line`=8'hA5, `rda`=1, `framing_err`=0, `overrun`=0.
  - Asserting `receive_read_en` then clears `rda` on the next `clk`.
- **Loopback:** connect `rxd` to the transmitter `txd` with a shared baud tick. Write 0x00, then 0xFF, then 0x3C.
  - Required: three completions with those values, in order.
  - `rda` is read between frames, and no flag is ever set.
- **Glitch:** pulse `rxd` low for 5 strobes, then high.
  - Required: FSM returns to IDLE; `rda`, `framing_err` and `overrun` all stay 0.
- **Framing error:** frame 0x81 with stop bit 0, then hold `rxd` low for 40 bit times.
  - Required: exactly one completion, with `receive_read_line`=8'h81, `framing_err`=1 and `rda`=1.
  - No second frame until `rxd` rises and falls again.
- **Overrun and simultaneous read:**
  - Send 0x11, then 0x22 without reading. Required: `receive_read_line`=8'h22 and `overrun`=1; a read clears both `rda` and `overrun`.
  - Repeat with `receive_read_en` asserted exactly on the completion cycle of 0x22. Required: `rda`=1 and `overrun`=0.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 4 of 0x5A, release, then send 0xC3.
  - Required: all outputs return to their reset values, and the next completion gives `receive_read_line`=8'hC3.
